// File: rtl/sn_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : sn_issue_queue
//  Description : SN-side issuer for work-list ops. Buffers {addr,len}
//                descriptors in a FIFO. The head descriptor is offered to the
//                dispatch controller, which takes it with SN_clr_next. The
//                module tracks taken-but-not-done ops and signals batch
//                completion and protocol errors back to the scheduler.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                push_valid/ready   - descriptor push handshake
//                push_addr/len      - pushed descriptor
//                SN_next_op         - head descriptor offered
//                SN_next_addr/len   - FIFO head contents
//                SN_clr_next        - consumer took head (1-cycle pulse)
//                SN_req_done        - one taken op completed (1-cycle pulse)
//                fifo_count         - queued descriptors
//                outstanding        - taken-not-done ops
//                batch_done         - 1-cycle pulse when all work drained
//                err                - sticky protocol error
//  Revision    : 1.0 - initial release
// ============================================================================
module sn_issue_queue #(
    parameter int ADDR_WIDTH  = 64,
    parameter int WL_LEN_BITS = 32,
    parameter int DEPTH       = 4,
    parameter int MAX_OUT     = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_valid,
    output logic                           push_ready,
    input  logic [ADDR_WIDTH-1:0]          push_addr,
    input  logic [WL_LEN_BITS-1:0]         push_len,
    output logic                           SN_next_op,
    output logic [ADDR_WIDTH-1:0]          SN_next_addr,
    output logic [WL_LEN_BITS-1:0]         SN_next_len,
    input  logic                           SN_clr_next,
    input  logic                           SN_req_done,
    output logic [$clog2(DEPTH+1)-1:0]     fifo_count,
    output logic [$clog2(MAX_OUT+1)-1:0]   outstanding,
    output logic                           batch_done,
    output logic                           err
);

    localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_OW = $clog2(MAX_OUT + 1);

    localparam logic [c_CW-1:0] c_DEPTH   = c_CW'(DEPTH);
    localparam logic [c_OW-1:0] c_MAX_OUT = c_OW'(MAX_OUT);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;

    logic [ADDR_WIDTH-1:0]  r_mem_addr [DEPTH];
    logic [WL_LEN_BITS-1:0] r_mem_len  [DEPTH];
    logic [c_PW-1:0]        r_wptr;
    logic [c_PW-1:0]        r_rptr;
    logic [c_CW-1:0]        r_count;
    logic [c_OW-1:0]        r_out;
    logic                   r_next_op;
    logic                   r_batch_done;
    logic                   r_err;
    logic [1:0]             r_state;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_done_ok;
    logic                   w_proto_err;
    logic [c_CW-1:0]        w_count_nxt;
    logic [c_OW-1:0]        w_out_nxt;

    // push_ready looks only at the current count, never at a same-cycle pop.
    assign w_push      = push_valid && (r_count != c_DEPTH);
    assign w_pop       = SN_clr_next && r_next_op;
    assign w_done_ok   = SN_req_done && (r_out != '0);
    assign w_proto_err = (SN_clr_next && !r_next_op) || (SN_req_done && (r_out == '0));

    // A valid pop together with a valid done leaves outstanding unchanged.
    assign w_count_nxt = r_count + c_CW'(w_push) - c_CW'(w_pop);
    assign w_out_nxt   = r_out + c_OW'(w_pop) - c_OW'(w_done_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_addr[i] <= '0;
                r_mem_len[i]  <= '0;
            end
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_out        <= '0;
            r_next_op    <= 1'b0;
            r_batch_done <= 1'b0;
            r_err        <= 1'b0;
            r_state      <= c_IDLE;
        end else begin
            if (w_push) begin
                r_mem_addr[r_wptr] <= push_addr;
                r_mem_len[r_wptr]  <= push_len;
                r_wptr             <= r_wptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PW'(1);
            end
            r_count <= w_count_nxt;
            r_out   <= w_out_nxt;

            // Offer is computed from next-state occupancy so it is a flop
            // that always agrees with the count registers it describes.
            r_next_op <= (w_count_nxt != '0) && (w_out_nxt < c_MAX_OUT);

            if (w_proto_err) begin
                r_err <= 1'b1;
            end

            r_batch_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_push) begin
                        r_state <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    if (w_count_nxt == '0) begin
                        if (w_out_nxt != '0) begin
                            r_state <= c_WAIT;
                        end else begin
                            r_state      <= c_IDLE;
                            r_batch_done <= 1'b1;
                        end
                    end
                end
                c_WAIT: begin
                    if (w_push) begin
                        r_state <= c_ISSUE;
                    end else if (w_out_nxt == '0) begin
                        r_state      <= c_IDLE;
                        r_batch_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign push_ready   = (r_count != c_DEPTH);
    assign SN_next_op   = r_next_op;
    assign SN_next_addr = r_mem_addr[r_rptr];
    assign SN_next_len  = r_mem_len[r_rptr];
    assign fifo_count   = r_count;
    assign outstanding  = r_out;
    assign batch_done   = r_batch_done;
    assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sn_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sn_issue_queue
//  Description : Self-checking bench for sn_issue_queue. Directed scenarios
//                followed by randomized traffic, compared every cycle against
//                a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sn_issue_queue;

    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic        clk;
    logic        rst;
    logic        push_valid;
    logic        push_ready;
    logic [63:0] push_addr;
    logic [31:0] push_len;
    logic        SN_next_op;
    logic [63:0] SN_next_addr;
    logic [31:0] SN_next_len;
    logic        SN_clr_next;
    logic        SN_req_done;
    logic [2:0]  fifo_count;
    logic [1:0]  outstanding;
    logic        batch_done;
    logic        err;

    sn_issue_queue #(
        .ADDR_WIDTH (64),
        .WL_LEN_BITS(32),
        .DEPTH      (DEPTH),
        .MAX_OUT    (MAX_OUT)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .push_valid  (push_valid),
        .push_ready  (push_ready),
        .push_addr   (push_addr),
        .push_len    (push_len),
        .SN_next_op  (SN_next_op),
        .SN_next_addr(SN_next_addr),
        .SN_next_len (SN_next_len),
        .SN_clr_next (SN_clr_next),
        .SN_req_done (SN_req_done),
        .fifo_count  (fifo_count),
        .outstanding (outstanding),
        .batch_done  (batch_done),
        .err         (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [63:0] a;
        logic [31:0] l;
    } desc_t;

    // Reference model state
    desc_t m_q[$];
    int    m_out;
    bit    m_err;
    bit    m_bd;
    bit    m_op;

    int n_checks;
    int n_pass;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, let the edge happen, advance the model
    // from the rules, then compare every observable output.
    task automatic step(input logic pv, input logic [63:0] a, input logic [31:0] l,
                        input logic c, input logic d, input logic r);
        bit    push_ok;
        bit    pop_ok;
        bit    was_busy;
        desc_t nd;
        push_valid  = pv;
        push_addr   = a;
        push_len    = l;
        SN_clr_next = c;
        SN_req_done = d;
        rst         = r;
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_out = 0;
            m_err = 0;
            m_bd  = 0;
        end else begin
            was_busy = (m_q.size() > 0) || (m_out > 0);
            push_ok  = pv && (m_q.size() < DEPTH);
            pop_ok   = c && m_op;
            if ((c && !m_op) || (d && m_out == 0)) m_err = 1;
            if (pop_ok) void'(m_q.pop_front());
            if (push_ok) begin
                nd.a = a;
                nd.l = l;
                m_q.push_back(nd);
            end
            m_out = m_out + (pop_ok ? 1 : 0) - ((d && m_out > 0) ? 1 : 0);
            m_bd  = was_busy && (m_q.size() == 0) && (m_out == 0);
        end
        m_op = (m_q.size() > 0) && (m_out < MAX_OUT);
        #1;
        push_valid  = 1'b0;
        SN_clr_next = 1'b0;
        SN_req_done = 1'b0;
        rst         = 1'b0;
        check("push_ready", 96'(push_ready), 96'(m_q.size() < DEPTH));
        check("next_op", 96'(SN_next_op), 96'(m_op));
        check("fifo_count", 96'(fifo_count), 96'(m_q.size()));
        check("outstanding", 96'(outstanding), 96'(m_out));
        check("batch_done", 96'(batch_done), 96'(m_bd));
        check("err", 96'(err), 96'(m_err));
        if (r) begin
            check("rst_addr", 96'(SN_next_addr), 96'(0));
            check("rst_len", 96'(SN_next_len), 96'(0));
        end else if (m_q.size() > 0) begin
            check("head_addr", 96'(SN_next_addr), 96'(m_q[0].a));
            check("head_len", 96'(SN_next_len), 96'(m_q[0].l));
        end
    endtask

    task automatic idle();
        step(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic reset_dut();
        step(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic push(input logic [63:0] a, input logic [31:0] l);
        step(1'b1, a, l, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        m_out       = 0;
        m_err       = 0;
        m_bd        = 0;
        m_op        = 0;
        rst         = 1'b1;
        push_valid  = 1'b0;
        push_addr   = '0;
        push_len    = '0;
        SN_clr_next = 1'b0;
        SN_req_done = 1'b0;

        reset_dut();
        reset_dut();

        // Reset drops a queued descriptor
        push(64'h1000, 32'd16);
        reset_dut();

        // Basic: push, offer, take, complete, batch_done pulse
        push(64'h1000, 32'd16);
        idle();
        step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 64'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        idle();
        idle();

        // Throttle at MAX_OUT
        push(64'h2000, 32'd1);
        push(64'h2100, 32'd0);
        push(64'h2200, 32'd3);
        step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        idle();
        step(1'b0, 64'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        idle();
        reset_dut();

        // Full and wrap
        for (int i = 0; i < 6; i++) push(64'h3000 + 64'(i), 32'(i));
        step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 64'h3100, 32'd7, 1'b0, 1'b1, 1'b0);
        step(1'b1, 64'h3200, 32'd8, 1'b1, 1'b0, 1'b0);
        step(1'b1, 64'h3300, 32'd9, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 64'h0, 32'h0, m_op, m_out > 0, 1'b0);
        idle();
        reset_dut();

        // Simultaneous clr and done with outstanding = 1
        push(64'h4000, 32'd4);
        push(64'h4100, 32'd5);
        step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 64'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 64'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        idle();
        reset_dut();

        // Errors: clr without offer, done with nothing outstanding
        step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        idle();
        reset_dut();
        step(1'b0, 64'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        idle();
        reset_dut();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic        pv;
            logic        c;
            logic        d;
            logic        r;
            logic [31:0] l;
            pv = ($urandom_range(0, 99) < 55);
            c  = m_op ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 2);
            d  = (m_out > 0) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 2);
            r  = ($urandom_range(0, 99) < 1);
            l  = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom);
            step(pv, {32'($urandom), 32'($urandom)}, l, c, d, r);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
